// File: rtl/vram_arbiter.sv
// vram_arbiter: owns the video RAM and time-shares its single port between
// display fetches (highest priority, fixed one-cycle latency) and CPU accesses
// (req/ack handshake with a one-entry posted-write buffer). After reset the
// whole RAM is cleared to 0x00 before CPU traffic is accepted.
module vram_arbiter #(
    parameter int DEPTH = 2048,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          ready,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [7:0]    vid_data,
    output logic          vid_valid
);

    typedef enum logic {CLEAR, RUN} stateT;

    stateT         state, stateNext;
    logic [AW-1:0] clearCnt, clearCntNext;

    logic          wbValid;
    logic [AW-1:0] wbAddr;
    logic [7:0]    wbData;

    logic [7:0]    mem [DEPTH];

    logic          cpuReqLive, drain, wrAccept, fwdHit, rdAccept, vidHit;
    logic          ramWe;
    logic [AW-1:0] ramAddr;
    logic [7:0]    ramWdata, ramRdata;

    assign ready    = (state == RUN);
    assign ramRdata = mem[ramAddr];

    // State register and clear counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clearCnt <= '0;
        end else begin
            state    <= stateNext;
            clearCnt <= clearCntNext;
        end
    end

    // Next state, acceptance decisions and RAM port arbitration
    always_comb begin
        stateNext    = state;
        clearCntNext = clearCnt;
        cpuReqLive   = 1'b0;
        drain        = 1'b0;
        wrAccept     = 1'b0;
        fwdHit       = 1'b0;
        rdAccept     = 1'b0;
        ramWe        = 1'b0;
        ramAddr      = vid_addr;
        ramWdata     = '0;
        vidHit       = wbValid && (wbAddr == vid_addr);
        case (state)
            CLEAR: begin
                ramWe        = 1'b1;
                ramAddr      = clearCnt;
                clearCntNext = clearCnt + 1'b1;
                if (clearCnt == '1) stateNext = RUN;
            end
            RUN: begin
                // The ack cycle swallows cpu_req so the CPU can change or drop it.
                cpuReqLive = cpu_req && !cpu_ack;
                fwdHit     = wbValid && (wbAddr == cpu_addr);
                drain      = wbValid && !vid_req;
                wrAccept   = cpuReqLive && cpu_we && (!wbValid || drain);
                // A different-address read must wait for the pending write to land.
                rdAccept   = cpuReqLive && !cpu_we && (fwdHit || (!wbValid && !vid_req));
                if (vid_req) begin
                    ramAddr = vid_addr;
                end else if (drain) begin
                    ramWe    = 1'b1;
                    ramAddr  = wbAddr;
                    ramWdata = wbData;
                end else begin
                    ramAddr = cpu_addr;
                end
            end
            default: stateNext = CLEAR;
        endcase
    end

    // RAM write port
    always_ff @(posedge clk) begin
        if (ramWe && !reset) mem[ramAddr] <= ramWdata;
    end

    // Posted-write buffer: load on accepted write, clear on drain
    always_ff @(posedge clk) begin
        if (reset) begin
            wbValid <= 1'b0;
            wbAddr  <= '0;
            wbData  <= '0;
        end else if (wrAccept) begin
            wbValid <= 1'b1;
            wbAddr  <= cpu_addr;
            wbData  <= cpu_wdata;
        end else if (drain) begin
            wbValid <= 1'b0;
        end
    end

    // Registered responses for video fetch and CPU completion
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_valid <= 1'b0;
            vid_data  <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            vid_valid <= vid_req;
            if (vid_req) begin
                if (state != RUN) vid_data <= '0;
                else if (vidHit)  vid_data <= wbData;
                else              vid_data <= ramRdata;
            end
            cpu_ack <= wrAccept || rdAccept;
            if (rdAccept) cpu_rdata <= fwdHit ? wbData : ramRdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus pushes expected
// responses (data and arrival cycle); a monitor pops and compares them.
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        ready;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        vid_req;
    logic [10:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;

    typedef struct {
        bit         isRead;
        logic [7:0] data;
        int         cyc;
    } cpuExpT;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } vidExpT;

    cpuExpT cpuQ[$];
    vidExpT vidQ[$];
    cpuExpT ce;
    vidExpT ve;

    int cyc     = 0;
    int nChecks = 0;
    int nFails  = 0;

    vram_arbiter #(.DEPTH(2048)) dut (
        .clk       (clk),
        .reset     (reset),
        .ready     (ready),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic setCpu(input bit req, input bit we, input logic [10:0] a, input logic [7:0] d);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    // Expect an ack one cycle after the cycle whose inputs are being set now.
    task automatic pushCpu(input bit isRead, input logic [7:0] d);
        cpuQ.push_back('{isRead: isRead, data: d, cyc: cyc + 1});
    endtask

    task automatic vid(input bit req, input logic [10:0] a, input logic [7:0] exp);
        vid_req  = req;
        vid_addr = a;
        if (req) vidQ.push_back('{data: exp, cyc: cyc + 1});
    endtask

    task automatic runClear(input bit probe);
        int firstReady;
        firstReady = -1;
        reset = 1'b0;
        for (int k = 1; k <= 2100 && firstReady < 0; k++) begin
            @(negedge clk);
            if (ready === 1'b1) firstReady = k;
            if (probe) begin
                setCpu((k >= 100 && k < 110), 1'b0, 11'h000, 8'h00);
                if (k >= 101 && k <= 111) check("clear_no_ack", cpu_ack, 0);
                if (k == 10) vid(1'b1, 11'h7FF, 8'h00);
                else         vid(1'b0, 11'h000, 8'h00);
            end
        end
        check("ready_cycle", firstReady, 2048);
    endtask

    // Monitor: compare every CPU ack and video pulse against the scoreboard
    always @(negedge clk) begin
        if (cpu_ack === 1'b1) begin
            if (cpuQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL cpu_ack_unexpected: got ack at cycle %0d expected none", cyc);
            end else begin
                ce = cpuQ.pop_front();
                check("cpu_ack_cycle", cyc, ce.cyc);
                if (ce.isRead) check("cpu_rdata", cpu_rdata, ce.data);
            end
        end
        if (vid_valid === 1'b1) begin
            if (vidQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL vid_valid_unexpected: got pulse at cycle %0d expected none", cyc);
            end else begin
                ve = vidQ.pop_front();
                check("vid_valid_cycle", cyc, ve.cyc);
                check("vid_data", vid_data, ve.data);
            end
        end
    end

    initial begin
        reset = 1'b1;
        setCpu(1'b0, 1'b0, 11'h000, 8'h00);
        vid_req  = 1'b0;
        vid_addr = 11'h000;
        repeat (3) step();
        check("rst_ready", ready, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_vid_valid", vid_valid, 0);
        check("rst_cpu_rdata", cpu_rdata, 8'h00);
        check("rst_vid_data", vid_data, 8'h00);

        // Clear phase, then video reads of cleared RAM
        runClear(1'b1);
        vid(1'b1, 11'h000, 8'h00); step();
        vid(1'b1, 11'h3FF, 8'h00); step();
        vid(1'b1, 11'h7FF, 8'h00); step();
        vid(1'b0, 11'h000, 8'h00); step();

        // Posted write, forwarded read under video, then RAM read
        setCpu(1'b1, 1'b1, 11'h123, 8'hA5); pushCpu(1'b0, 8'h00); step();
        setCpu(1'b1, 1'b0, 11'h123, 8'h00); vid(1'b1, 11'h000, 8'h00); step();
        vid(1'b1, 11'h001, 8'h00); pushCpu(1'b1, 8'hA5); step();
        setCpu(1'b0, 1'b0, 11'h000, 8'h00); vid(1'b0, 11'h000, 8'h00); step();
        setCpu(1'b1, 1'b0, 11'h123, 8'h00); pushCpu(1'b1, 8'hA5); step();
        setCpu(1'b0, 1'b0, 11'h000, 8'h00); step();

        // Video priority: second write stalls until vid_req drops
        setCpu(1'b1, 1'b1, 11'h010, 8'h5A); vid(1'b1, 11'h000, 8'h00); pushCpu(1'b0, 8'h00); step();
        setCpu(1'b1, 1'b1, 11'h020, 8'h77); vid(1'b1, 11'h001, 8'h00); step();
        vid(1'b1, 11'h002, 8'h00); step();
        vid(1'b1, 11'h003, 8'h00); step();
        vid(1'b0, 11'h000, 8'h00); pushCpu(1'b0, 8'h00); step();
        setCpu(1'b0, 1'b0, 11'h000, 8'h00); step();
        setCpu(1'b1, 1'b0, 11'h010, 8'h00); pushCpu(1'b1, 8'h5A); step();
        setCpu(1'b1, 1'b0, 11'h020, 8'h00); step();
        pushCpu(1'b1, 8'h77); step();
        setCpu(1'b0, 1'b0, 11'h000, 8'h00); step();

        // Video coherence with the write buffer
        setCpu(1'b1, 1'b1, 11'h7F0, 8'h3C); vid(1'b1, 11'h7F0, 8'h00); pushCpu(1'b0, 8'h00); step();
        setCpu(1'b0, 1'b0, 11'h000, 8'h00); vid(1'b1, 11'h7F0, 8'h3C); step();
        vid(1'b1, 11'h7F0, 8'h3C); step();
        vid(1'b0, 11'h000, 8'h00); step();
        vid(1'b1, 11'h7F0, 8'h3C); step();
        vid(1'b0, 11'h000, 8'h00); step();

        // Ordering: different-address read waits for the drain
        setCpu(1'b1, 1'b1, 11'h050, 8'h11); vid(1'b1, 11'h100, 8'h00); pushCpu(1'b0, 8'h00); step();
        setCpu(1'b1, 1'b0, 11'h051, 8'h00); vid(1'b1, 11'h101, 8'h00); step();
        vid(1'b1, 11'h102, 8'h00); step();
        vid(1'b1, 11'h103, 8'h00); step();
        vid(1'b0, 11'h000, 8'h00); step();
        pushCpu(1'b1, 8'h00); step();
        setCpu(1'b0, 1'b0, 11'h000, 8'h00); step();
        setCpu(1'b1, 1'b0, 11'h050, 8'h00); pushCpu(1'b1, 8'h11); step();
        setCpu(1'b0, 1'b0, 11'h000, 8'h00); step();

        // Reset with a write still buffered
        setCpu(1'b1, 1'b1, 11'h200, 8'h99); vid(1'b1, 11'h000, 8'h00); pushCpu(1'b0, 8'h00); step();
        setCpu(1'b0, 1'b0, 11'h000, 8'h00); vid(1'b0, 11'h000, 8'h00); reset = 1'b1; step();
        check("rst2_ready", ready, 0);
        check("rst2_cpu_ack", cpu_ack, 0);
        check("rst2_vid_valid", vid_valid, 0);
        step();
        runClear(1'b0);
        setCpu(1'b1, 1'b0, 11'h200, 8'h00); pushCpu(1'b1, 8'h00); step();
        setCpu(1'b1, 1'b0, 11'h123, 8'h00); step();
        pushCpu(1'b1, 8'h00); step();
        setCpu(1'b0, 1'b0, 11'h000, 8'h00); step();

        repeat (4) step();
        check("cpu_queue_drained", cpuQ.size(), 0);
        check("vid_queue_drained", vidQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
